// File: rtl/operand_fetch.sv
// Issue stage: 32-entry register file, pending-destination scoreboard and a
// registered {cmd, lhs, rhs, rd} ALU interface. Build option: OPFETCH_BYPASS_EN.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CMDW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CMDW-1:0] in_cmd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CMDW-1:0] out_cmd,
  output logic [XLEN-1:0] out_lhs,
  output logic [XLEN-1:0] out_rhs,
  output logic [4:0]      out_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;

  logic             out_valid_q, out_valid_d;
  logic [CMDW-1:0]  out_cmd_q, out_cmd_d;
  logic [XLEN-1:0]  out_lhs_q, out_lhs_d;
  logic [XLEN-1:0]  out_rhs_q, out_rhs_d;
  logic [4:0]       out_rd_q, out_rd_d;

  logic             wb_wr;
  logic             wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic             fwd_rs1, fwd_rs2;
  logic             src_hz_rs1, src_hz_rs2, waw_hz, hazard;
  logic             accept;
  logic [XLEN-1:0]  rs1_val, rs2_val, rhs_val;

  assign wb_wr      = wb_en && (wb_rd != 5'd0);
  assign wb_hit_rs1 = wb_en && (wb_rd == in_rs1);
  assign wb_hit_rs2 = wb_en && (wb_rd == in_rs2);
  assign wb_hit_rd  = wb_en && (wb_rd == in_rd);

`ifdef OPFETCH_BYPASS_EN
  assign fwd_rs1 = wb_hit_rs1;
  assign fwd_rs2 = wb_hit_rs2;
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  // A forwarded source is no longer a hazard; WAW may always release on the
  // writeback of the same destination since the new pending bit wins.
  assign src_hz_rs1 = (in_rs1 != 5'd0) && pending_q[in_rs1] && !fwd_rs1;
  assign src_hz_rs2 = (in_rs2 != 5'd0) && pending_q[in_rs2] && !fwd_rs2;
  assign waw_hz     = (in_rd != 5'd0) && pending_q[in_rd] && !wb_hit_rd;
  assign hazard     = src_hz_rs1 || (!in_use_imm && src_hz_rs2) || waw_hz;

  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    rs1_val = '0;
    if (in_rs1 != 5'd0) begin
      rs1_val = fwd_rs1 ? wb_data : regs_q[in_rs1];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (in_rs2 != 5'd0) begin
      rs2_val = fwd_rs2 ? wb_data : regs_q[in_rs2];
    end
  end

  assign rhs_val = in_use_imm ? in_imm : rs2_val;

  always_comb begin
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    out_lhs_d   = out_lhs_q;
    out_rhs_d   = out_rhs_q;
    out_rd_d    = out_rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_cmd_d   = in_cmd;
      out_lhs_d   = rs1_val;
      out_rhs_d   = rhs_val;
      out_rd_d    = in_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear before set so a same-cycle issue to the written register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_wr) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (accept && (in_rd != 5'd0)) begin
      pending_d[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_lhs_q   <= '0;
      out_rhs_q   <= '0;
      out_rd_q    <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_lhs_q   <= out_lhs_d;
      out_rhs_q   <= out_rhs_d;
      out_rd_q    <= out_rd_d;
      pending_q   <= pending_d;
    end
  end

  // Entry 0 is cleared on reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_wr) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_cmd   = out_cmd_q;
  assign out_lhs   = out_lhs_q;
  assign out_rhs   = out_rhs_q;
  assign out_rd    = out_rd_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the combinational ALU.
- Holds the 32x32 integer register file and reads rs1/rs2, or selects an immediate for rhs.
- Tracks pending destinations with a scoreboard and stalls on hazards.
- Presents a registered {command, lhs, rhs, rd} to the ALU under a valid/ready handshake. Writeback returns through a dedicated write port.

Parameters:
- XLEN, 32, operand/data width.
- NREGS, 32, register count; register 0 is hardwired to zero.
- CMDW, 4, ALU command width; the command passes through unmodified (ADD=0 … GEU=13).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_cmd  in  CMDW  ALU command.
- in_rs1  in  5  lhs source register.
- in_rs2  in  5  rhs source register; ignored when in_use_imm=1.
- in_rd  in  5  destination register; 0 means no writeback.
- in_use_imm  in  1  rhs = in_imm instead of reg[rs2].
- in_imm  in  XLEN  immediate, already sign-extended.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream consumes the operands.
- out_cmd  out  CMDW  registered command.
- out_lhs  out  XLEN  registered lhs.
- out_rhs  out  XLEN  registered rhs.
- out_rd  out  5  registered destination.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback register.
- wb_data  in  XLEN  writeback value.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0; out_cmd/out_lhs/out_rhs/out_rd=0.
  - Scoreboard pending[NREGS-1:0]=0; all registers=0.
  - An in-flight instruction is discarded.
- Handshake:
  - Transfer on in_valid&&in_ready; output consumed on out_valid&&out_ready.
  - in_ready = !hazard && (!out_valid || out_ready), combinational.
  - in_ready must not depend on in_valid.
  - Output registers hold stable while out_valid&&!out_ready.
- Latency: one cycle from accept to out_valid. Back-to-back issue gives 1 instruction/cycle.
- out_valid next = accept ? 1 : (out_ready ? 0 : out_valid).
- Register file:
  - wb_en with wb_rd!=0 writes reg[wb_rd]=wb_data at the clock edge.
  - Writes to register 0 are ignored; reads of register 0 return 0.
- Operand read is combinational in the accept cycle:
  - lhs = rd(rs1).
  - rhs = in_use_imm ? in_imm : rd(rs2).
- Scoreboard:
  - Accept with in_rd!=0 sets pending[in_rd].
  - wb_en with wb_rd!=0 clears pending[wb_rd].
  - Same register set and cleared in one cycle: set wins.
  - wb_en to a non-pending register still writes the array; it is not an error.
- hazard = src_hz(rs1) || (!in_use_imm && src_hz(rs2)) || (in_rd!=0 && pending[in_rd] && !wb_hit(in_rd)).
  - Read-after-write (RAW) and write-after-write (WAW) both stall.
  - src_hz(r) = r!=0 && pending[r] && !fwd(r).
  - wb_hit(r) = wb_en && wb_rd==r.
  - fwd(r) is defined under Optional Feature.
- hazard is evaluated only when in_valid=1. in_ready still reflects it otherwise.
- No flush; recovery is by reset only.

Optional Feature:
- Macro: OPFETCH_BYPASS_EN.
- Defined: fwd(r)=wb_hit(r). An operand whose writeback arrives in the accept cycle takes wb_data directly, with no stall.
- Undefined: fwd(r)=0. A source pending in the writeback cycle stalls that cycle and is accepted next cycle from the array.
- WAW release via wb_hit(in_rd) applies in both builds.

Test Plan:
- Reset, then issue {ADD, rs1=0, use_imm, imm=0x5, rd=3} -> next cycle out_valid=1, out_lhs=0, out_rhs=5, out_rd=3, pending[3]=1.
- Issue rd=3; next instr reads rs1=3 while wb not yet returned -> in_ready=0 until wb_en, wb_rd=3, wb_data=0xDEADBEEF. Bypass build: accepts that cycle with lhs=0xDEADBEEF. Non-bypass build: accepts one cycle later with the same value.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; release -> next queued instruction issues the following cycle.
- wb_en, wb_rd=0, wb_data=0x1234, then read rs1=0 -> lhs=0, no stall.
- Two instrs both rd=7, no wb -> second stalls (WAW) until wb_rd=7; same-cycle accept rd=7 with wb_rd=7 -> pending[7] remains 1.
- Assert rst_n=0 mid-stall with pending[5]=1 and out_valid=1 -> out_valid=0, pending all 0, reg[5]=0 immediately (async).
